// File: rtl/code_loader_pkg.sv
// Shared definitions for the codemem program loader: state encodings and
// the instruction/beat widths used by codemem and fetch.
package code_loader_pkg;

   localparam int INST_WIDTH = 64;
   localparam int BEAT_WIDTH = 32;

   localparam logic [1:0] LDR_IDLE  = 2'd0;
   localparam logic [1:0] LDR_LOAD  = 2'd1;
   localparam logic [1:0] LDR_DRAIN = 2'd2;

endpackage

// File: rtl/code_loader.sv
// Packs 32-bit program beats into 64-bit instructions and writes them
// sequentially into codemem from address 0 while the CPU is idle.
module code_loader
   import code_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = INST_WIDTH,
   parameter int IN_WIDTH   = BEAT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  cpu_idle,
   input  logic [IN_WIDTH-1:0]   s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH:0]   inst_count,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  load_err
);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  half;
   logic [IN_WIDTH-1:0]   hi;
   logic                  accept;
   logic [ADDR_WIDTH:0]   addr_p1;

   assign s_ready   = (state == LDR_LOAD) || (state == LDR_DRAIN);
   assign load_busy = (state == LDR_LOAD);
   assign accept    = s_valid & s_ready;
   assign addr_p1   = {1'b0, addr} + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LDR_IDLE;
         addr       <= '0;
         half       <= 1'b0;
         hi         <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         inst_count <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            LDR_IDLE: begin
               if (load_start && cpu_idle) begin
                  state      <= LDR_LOAD;
                  addr       <= '0;
                  half       <= 1'b0;
                  inst_count <= '0;
                  load_done  <= 1'b0;
                  load_err   <= 1'b0;
               end
            end
            LDR_LOAD: begin
               if (!cpu_idle) begin
                  // CPU resumed fetching: abandon the load, keep what was written
                  load_err   <= 1'b1;
                  inst_count <= {1'b0, addr};
                  half       <= 1'b0;
                  state      <= (accept && s_last) ? LDR_IDLE : LDR_DRAIN;
               end else if (accept) begin
                  if (!half) begin
                     hi   <= s_data;
                     half <= 1'b1;
                     if (s_last) begin
                        load_err <= 1'b1;
                        half     <= 1'b0;
                        state    <= LDR_IDLE;
                     end
                  end else begin
                     wr_en   <= 1'b1;
                     wr_addr <= addr;
                     wr_data <= {hi, s_data};
                     half    <= 1'b0;
                     if (s_last) begin
                        inst_count <= addr_p1;
                        load_done  <= 1'b1;
                        state      <= LDR_IDLE;
                     end else if (&addr) begin
                        // memory full with beats still pending; addr must not wrap
                        inst_count <= addr_p1;
                        load_err   <= 1'b1;
                        state      <= LDR_DRAIN;
                     end else begin
                        addr <= addr + 1'b1;
                     end
                  end
               end
            end
            LDR_DRAIN: begin
               if (accept && s_last) state <= LDR_IDLE;
            end
            default: state <= LDR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_code_loader.sv
// Randomized scoreboard bench for code_loader (small ADDR_WIDTH so the
// overflow path is reachable).
module tb_code_loader;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n, load_start, cpu_idle, s_valid, s_last;
   logic [31:0]   s_data;
   logic          s_ready, wr_en, load_busy, load_done, load_err;
   logic [AW-1:0] wr_addr;
   logic [63:0]   wr_data;
   logic [AW:0]   inst_count;

   code_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .IN_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .cpu_idle(cpu_idle),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .inst_count(inst_count),
      .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [63:0]   data;
   } wr_t;

   int          tests = 0;
   int          fails = 0;
   wr_t         exp_q[$];
   logic [31:0] beats[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // scoreboard monitor: every write strobe must match the next expected write
   always @(negedge clk) begin : mon
      wr_t e;
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write got addr=%0d data=%0h exp none", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {61'd0, wr_addr}, {61'd0, e.addr});
            chk("wr_data", wr_data, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gen_beats(input int n);
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back($urandom);
   endtask

   task automatic push_writes(input int nw);
      wr_t w;
      for (int i = 0; i < nw; i++) begin
         w.addr = i[AW-1:0];
         w.data = {beats[2*i], beats[2*i+1]};
         exp_q.push_back(w);
      end
   endtask

   // reference: outcome of an uninterrupted n-beat program
   task automatic model_load(input int n, output logic done, output logic err, output int cnt);
      int pairs;
      pairs = n / 2;
      if (n > 2 * DEPTH) begin
         push_writes(DEPTH); done = 1'b0; err = 1'b1; cnt = DEPTH;
      end else if (n % 2 == 1) begin
         push_writes(pairs); done = 1'b0; err = 1'b1; cnt = 0;
      end else begin
         push_writes(pairs); done = 1'b1; err = 1'b0; cnt = pairs;
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last, input int gapmax);
      int cyc;
      s_valid = 1'b0;
      repeat ($urandom_range(0, gapmax)) tick();
      s_valid = 1'b1; s_data = d; s_last = last;
      cyc = 0;
      while (!s_ready && cyc < 50) begin
         tick();
         cyc++;
      end
      if (!s_ready) begin
         tests++; fails++;
         $display("FAIL beat_timeout got s_ready=0 exp 1");
      end
      tick();
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic run_load(input int n, input int gapmax);
      logic done, err;
      int   cnt;
      gen_beats(n);
      model_load(n, done, err, cnt);
      start_load();
      chk("busy_after_start", {63'd0, load_busy}, 64'd1);
      for (int i = 0; i < n; i++) send_beat(beats[i], (i == n - 1), gapmax);
      repeat (3) tick();
      chk("load_done", {63'd0, load_done}, {63'd0, done});
      chk("load_err", {63'd0, load_err}, {63'd0, err});
      chk("inst_count", {60'd0, inst_count}, cnt);
      chk("s_ready_idle", {63'd0, s_ready}, 64'd0);
      chk("writes_pending", exp_q.size(), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; load_start = 1'b0; cpu_idle = 1'b1;
      s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      repeat (3) tick();
      chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
      chk("rst_done", {63'd0, load_done}, 64'd0);
      chk("rst_err", {63'd0, load_err}, 64'd0);
      chk("rst_count", {60'd0, inst_count}, 64'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      rst_n = 1'b1;
      tick();

      run_load(8, 0);    // 4 instructions, back-to-back
      run_load(3, 0);    // odd length
      run_load(18, 1);   // 9 instructions into an 8-deep memory

      // start request while CPU busy must be ignored
      cpu_idle = 1'b0;
      start_load();
      repeat (3) tick();
      chk("busy_start_s_ready", {63'd0, s_ready}, 64'd0);
      chk("busy_start_busy", {63'd0, load_busy}, 64'd0);
      chk("busy_start_err", {63'd0, load_err}, 64'd1);
      chk("busy_start_count", {60'd0, inst_count}, 64'd8);
      cpu_idle = 1'b1;

      // CPU resumes after 2 instructions
      gen_beats(8);
      push_writes(2);
      start_load();
      for (int i = 0; i < 4; i++) send_beat(beats[i], 1'b0, 1);
      repeat (2) tick();
      cpu_idle = 1'b0;
      tick();
      chk("cpu_drop_err", {63'd0, load_err}, 64'd1);
      chk("cpu_drop_busy", {63'd0, load_busy}, 64'd0);
      chk("cpu_drop_drain_ready", {63'd0, s_ready}, 64'd1);
      for (int i = 4; i < 8; i++) send_beat(beats[i], (i == 7), 1);
      repeat (3) tick();
      chk("cpu_drop_count", {60'd0, inst_count}, 64'd2);
      chk("cpu_drop_done", {63'd0, load_done}, 64'd0);
      chk("cpu_drop_s_ready", {63'd0, s_ready}, 64'd0);
      chk("cpu_drop_pending", exp_q.size(), 64'd0);
      cpu_idle = 1'b1;

      run_load(10, 3);   // 5 instructions with backpressure gaps

      // reset after the first beat of an instruction
      gen_beats(2);
      start_load();
      send_beat(beats[0], 1'b0, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", {63'd0, wr_en}, 64'd0);
      chk("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
      chk("mid_rst_wr_addr", {61'd0, wr_addr}, 64'd0);
      chk("mid_rst_wr_data", wr_data, 64'd0);
      chk("mid_rst_count", {60'd0, inst_count}, 64'd0);
      chk("mid_rst_busy", {63'd0, load_busy}, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      run_load(4, 1);

      for (int k = 0; k < 6; k++) run_load($urandom_range(1, 20), 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
